// File: rtl/ahb_imem_responder.sv
// ahb_imem_responder: AHB-Lite read-only instruction memory with wait states, two-cycle errors and a side load port
module ahb_imem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 1
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           hsel_in,
   input  logic [31:0]                    haddr_in,
   input  logic [1:0]                     htrans_in,
   input  logic                           hwrite_in,
   input  logic [2:0]                     hsize_in,
   input  logic                           hready_in,
   output logic [31:0]                    hrdata_out,
   output logic                           hreadyout_out,
   output logic                           hresp_out,
   input  logic                           load_en_in,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_in,
   input  logic [31:0]                    load_data_in
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
   logic [31:0] mem [DEPTH_WORDS];
   state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic [AW-1:0] idx, idx_nx;
   logic [31:0] off;
   logic go, bad, unused_trans;
   assign off = haddr_in - BASE_ADDR;
   assign go = (state == S_IDLE || state == S_DATA || state == S_ERR2) && hsel_in && htrans_in[1] && hready_in;
   // BASE_ADDR is word aligned, so offset low bits equal address low bits
   assign bad = hwrite_in || off[1:0] != 2'b00 || hsize_in != 3'b010 || off[31:AW+2] != '0;
   assign hreadyout_out = !(state == S_WAIT || state == S_ERR1);
   assign hresp_out = state == S_ERR1 || state == S_ERR2;
   assign unused_trans = htrans_in[0];
   always_comb begin
      state_nx = S_IDLE;
      cnt_nx = cnt;
      idx_nx = idx;
      if (go) begin
         idx_nx = off[AW+1:2];
         cnt_nx = 4'(WAIT_STATES);
         state_nx = bad ? S_ERR1 : (WAIT_STATES == 0 ? S_DATA : S_WAIT);
      end else if (state == S_WAIT) begin
         cnt_nx = cnt - 4'd1;
         state_nx = cnt == 4'd1 ? S_DATA : S_WAIT;
      end else if (state == S_ERR1) begin
         state_nx = S_ERR2;
      end
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= S_IDLE;
         cnt <= '0;
         idx <= '0;
         hrdata_out <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         idx <= idx_nx;
         if (state_nx == S_DATA) hrdata_out <= mem[idx_nx];
      end
   end
   // same-edge load and read: the read sees the old word
   always_ff @(posedge clk_in) begin
      if (load_en_in) mem[load_addr_in] <= load_data_in;
   end
endmodule
